// File: rtl/tinyqv_alu_seq_if.sv
// Request, nibble-ALU and result buses of the nibble-serial ALU sequencer.
// The sequencer uses the slave modport; the requester and nibble ALU use master.
interface tinyqv_alu_seq_if;
    // Handshakes: a transfer happens on a rising clk edge where valid and ready are
    // both high. Once valid is raised, the payload holds until that transfer.
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;

    logic [3:0]  alu_op;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic        alu_cy_in;
    logic        alu_cmp_in;
    logic [3:0]  alu_d;
    logic        alu_cy_out;
    logic        alu_cmp_out;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_d;
    logic        out_cy;
    logic        out_cmp;
    logic        busy;

    modport slave (
        input  in_valid, in_op, in_a, in_b, alu_d, alu_cy_out, alu_cmp_out, out_ready,
        output in_ready, alu_op, alu_a, alu_b, alu_cy_in, alu_cmp_in,
               out_valid, out_d, out_cy, out_cmp, busy
    );

    modport master (
        output in_valid, in_op, in_a, in_b, alu_d, alu_cy_out, alu_cmp_out, out_ready,
        input  in_ready, alu_op, alu_a, alu_b, alu_cy_in, alu_cmp_in,
               out_valid, out_d, out_cy, out_cmp, busy
    );
endinterface

// File: rtl/tinyqv_alu_seq.sv
// Drives a 32-bit operation through an external 4-bit ALU, low nibble first.
// Define ALU_SEQ_PIPE_EN to accept the next request in the same edge as the result handshake.
module tinyqv_alu_seq (
    input  logic             clk,
    input  logic             rst,
    tinyqv_alu_seq_if.slave  bus,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [3:0]  op_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] d_reg;
    logic        cy_reg;
    logic        cmp_reg;
    logic        out_fire;
    logic        accept;

    assign out_fire = (state == DONE) && bus.out_ready;

`ifdef ALU_SEQ_PIPE_EN
    assign bus.in_ready = !rst && ((state == IDLE) || out_fire);
`else
    assign bus.in_ready = !rst && (state == IDLE);
`endif

    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_d     = d_reg;
    assign bus.out_cy    = cy_reg;
    assign bus.out_cmp   = cmp_reg;
    assign dbg_state     = state;

    // Subtract-style ops (SUB/SLT/SLTU) seed the carry chain with 1 for two's complement.
    always_comb begin
        bus.alu_op     = op_reg;
        bus.alu_a      = 4'd0;
        bus.alu_b      = 4'd0;
        bus.alu_cy_in  = 1'b0;
        bus.alu_cmp_in = 1'b0;
        if (state == RUN) begin
            bus.alu_a      = a_reg[{cnt, 2'b00} +: 4];
            bus.alu_b      = b_reg[{cnt, 2'b00} +: 4];
            bus.alu_cy_in  = (cnt == 3'd0) ? (op_reg[1] | op_reg[3]) : cy_reg;
            bus.alu_cmp_in = (cnt == 3'd0) ? 1'b1 : cmp_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            op_reg  <= 4'd0;
            a_reg   <= 32'd0;
            b_reg   <= 32'd0;
            d_reg   <= 32'd0;
            cy_reg  <= 1'b0;
            cmp_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_reg <= bus.in_op;
                        a_reg  <= bus.in_a;
                        b_reg  <= bus.in_b;
                        cnt    <= 3'd0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    d_reg[{cnt, 2'b00} +: 4] <= bus.alu_d;
                    cy_reg  <= bus.alu_cy_out;
                    cmp_reg <= bus.alu_cmp_out;
                    cnt     <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // accept can only be high here when back-to-back operation is built in
                    if (out_fire) begin
                        if (accept) begin
                            op_reg <= bus.in_op;
                            a_reg  <= bus.in_a;
                            b_reg  <= bus.in_b;
                            cnt    <= 3'd0;
                            state  <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tinyqv_alu_seq.sv
// Directed bench for tinyqv_alu_seq with a behavioural nibble ALU and a result scoreboard.
// Build with ALU_SEQ_PIPE_EN defined to exercise back-to-back operation.
module tb_tinyqv_alu_seq;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0100;
`ifdef ALU_SEQ_PIPE_EN
    localparam int SPACING = 9;
`else
    localparam int SPACING = 10;
`endif

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         cyc;
    int         checks;
    int         errors;

    tinyqv_alu_seq_if bus ();

    tinyqv_alu_seq dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // behavioural nibble ALU
    logic [3:0] nb;
    logic [4:0] nsum;
    always_comb begin
        nb = (bus.alu_op[1] | bus.alu_op[3]) ? ~bus.alu_b : bus.alu_b;
        nsum = {1'b0, bus.alu_a} + {1'b0, nb} + {4'd0, bus.alu_cy_in};
        bus.alu_d       = nsum[3:0];
        bus.alu_cy_out  = nsum[4];
        bus.alu_cmp_out = 1'b0;
        case (bus.alu_op)
            OP_SLT:  bus.alu_cmp_out = (bus.alu_a[3] ^ bus.alu_b[3]) ? bus.alu_a[3] : ~nsum[4];
            OP_SLTU: bus.alu_cmp_out = ~nsum[4];
            OP_AND: begin
                bus.alu_d = bus.alu_a & bus.alu_b;
                bus.alu_cy_out = 1'b0;
            end
            OP_OR: begin
                bus.alu_d = bus.alu_a | bus.alu_b;
                bus.alu_cy_out = 1'b0;
            end
            OP_XOR: begin
                bus.alu_d = bus.alu_a ^ bus.alu_b;
                bus.alu_cy_out = 1'b0;
                bus.alu_cmp_out = bus.alu_cmp_in && (bus.alu_a == bus.alu_b);
            end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard
    logic [33:0] exp_q[$];
    int          acc_q[$];
    logic        held;
    logic [33:0] held_v;
    logic        stream_on;
    int          last_rise;

    always @(negedge clk) begin
        logic [33:0] act;
        int a;
        act = {bus.out_d, bus.out_cy, bus.out_cmp};
        if (!stream_on) last_rise = -1;
        if (!rst && bus.out_valid) begin
            if (!held) begin
                held   = 1'b1;
                held_v = act;
                chk("busy_done", 64'(bus.busy), 64'd1);
                if (acc_q.size() == 0) begin
                    chk("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
                end else begin
                    a = acc_q.pop_front();
                    chk("latency", 64'(cyc - a), 64'd8);
                end
                if (stream_on) begin
                    if (last_rise >= 0) chk("spacing", 64'(cyc - last_rise), 64'(SPACING));
                    last_rise = cyc;
                end
            end else begin
                chk("hold", 64'(act), 64'(held_v));
            end
            if (!bus.out_ready) begin
                chk("in_ready_stall", 64'(bus.in_ready), 64'd0);
            end else begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("result_no_exp", 64'(bus.out_valid), 64'd0);
                end else begin
                    chk("result", 64'(act), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // driver: call at posedge+1; leaves in_valid high on return
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] d, input logic cy, input logic cmp);
        int n;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 64) begin
            n = n + 1;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 64'(bus.in_ready), 64'd1);
        end else begin
            acc_q.push_back(cyc + 1);
            exp_q.push_back({d, cy, cmp});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            n = n + 1;
            @(posedge clk);
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic one(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] d, input logic cy, input logic cmp);
        send(op, a, b, d, cy, cmp);
        bus.in_valid = 1'b0;
        drain();
    endtask

    initial begin
        cyc = 0;
        checks = 0;
        errors = 0;
        held = 1'b0;
        held_v = '0;
        stream_on = 1'b0;
        last_rise = -1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_op = 4'd0;
        bus.in_a = 32'd0;
        bus.in_b = 32'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
        chk("idle_state", 64'(dbg_state), 64'd0);
        chk("idle_out", 64'({bus.out_valid, bus.out_d, bus.out_cy, bus.out_cmp, bus.busy}), 64'd0);
        chk("idle_alu_in", 64'({bus.alu_a, bus.alu_b, bus.alu_cy_in, bus.alu_cmp_in}), 64'd0);
        @(posedge clk);
        #1;

        one(OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
        one(OP_ADD,  32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0);
        one(OP_SUB,  32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b0);
        one(OP_SLT,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1);
        one(OP_SLTU, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0);
        one(OP_SLT,  32'h00000001, 32'h80000000, 32'h80000001, 1'b0, 1'b0);
        one(OP_XOR,  32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1'b1);
        one(OP_XOR,  32'h12345678, 32'h12345679, 32'h00000001, 1'b0, 1'b0);
        one(OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0);
        one(OP_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0);

        // result held while out_ready is low
        bus.out_ready = 1'b0;
        send(OP_ADD, 32'h0000000F, 32'h00000001, 32'h00000010, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        repeat (5) @(posedge clk);
        #1;
        chk("stall_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        drain();

        // reset while the counter is at 3 discards the operation
        send(OP_ADD, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        exp_q.delete();
        acc_q.delete();
        chk("abort_state", 64'(dbg_state), 64'd0);
        chk("abort_out", 64'({bus.out_valid, bus.busy, bus.out_d, bus.out_cy, bus.out_cmp}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        one(OP_SUB, 32'h00000010, 32'h00000001, 32'h0000000F, 1'b1, 1'b0);

        // in_valid and out_ready held high across three requests
        stream_on = 1'b1;
        send(OP_ADD, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0);
        send(OP_ADD, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b0);
        send(OP_ADD, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        drain();
        stream_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
